ecore_ram_arbiter: RTL and testbench
====================================

Name: ecore_ram_arbiter

Overview:
Two-master arbiter that shares the single synchronous data RAM port.
- Master 0 is the ecore load/store port; master 1 is the loader/debug port.
- Selection is round-robin with a bounded burst allowance. Grants are combinational. Read returns are tracked through a one-stage pipeline and routed back to the issuing master.
- Sits between the core and the RAM macro; the RAM-side port matches the core's RAM port format.

Parameters:
MAX_BURST, 4, max consecutive grants to one master while the other master is requesting (legal range 1..15; 1 gives strict alternation)
BURST_W, 4, width of the burst counter; must satisfy 2^BURST_W > MAX_BURST

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, synchronous, active-high
i_m0_req  in  1  master 0 access request, held until granted
i_m0_we  in  4  master 0 byte write enables; 0 = read
i_m0_addr  in  30  master 0 word address
i_m0_wdata  in  32  master 0 write data
o_m0_gnt  out  1  master 0 granted this cycle (combinational)
o_m0_rvalid  out  1  master 0 read data valid
o_m0_rdata  out  32  master 0 read data
i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as master 0, for master 1
o_ram_we  out  4  RAM byte write enables
o_ram_addr  out  30  RAM word address
o_ram_wdata  out  32  RAM write data
i_ram_rdata  in  32  RAM read data, valid 1 cycle after address

Behaviour:
State:
- last_gnt (1b): master of most recent grant.
- prev_active (1b): a grant occurred in the previous cycle.
- burst_cnt (BURST_W): consecutive grants to last_gnt.
- rd_pend (1b) and rd_owner (1b).

Reset (i_rst high at the edge):
- last_gnt=1, so master 0 wins the first contest.
- prev_active=0, burst_cnt=0, rd_pend=0.
- Outputs: gnt=0 while in reset; o_ram_we=0; o_ram_addr=0; o_ram_wdata=0; rvalid=0; rdata=0.

Arbitration (combinational, each cycle):
- No req: no grant; o_ram_we=0, addr/wdata=0.
- Exactly one req: that master is granted.
- Both req, and prev_active=1 and burst_cnt<MAX_BURST: last_gnt is granted again.
- Both req, otherwise: grant goes to ~last_gnt.
- Granted master's we/addr/wdata drive the RAM port. The same master's o_mX_gnt=1 in that cycle and the access completes at that edge.

Sequential update on a grant:
- If granted==last_gnt and prev_active: burst_cnt increments, saturating at MAX_BURST.
- Otherwise: burst_cnt=1.
- Then last_gnt=granted and prev_active=1.

Sequential update with no grant:
- prev_active=0.
- burst_cnt and last_gnt are held. An idle cycle ends a burst, so the next contest goes to ~last_gnt.

Read return:
- A granted access with we==0 sets rd_pend=1 and rd_owner=granted at the edge. Otherwise rd_pend=0.
- While rd_pend=1: o_m{rd_owner}_rvalid=1 and o_m{rd_owner}_rdata=i_ram_rdata. The other master's rdata=0.
- Read latency is exactly 1 cycle after gnt.
- Back-to-back reads, including alternating masters, sustain 1 access/cycle. A new grant in the rvalid cycle is legal.

Writes:
- No response.
- A write granted in the cycle after a read does not disturb the rvalid of that read.

Boundary conditions:
- Reset asserted while rd_pend=1: no rvalid is produced in the following cycle.
- A master dropping req mid-burst counts as an idle cycle for that master only. If the other master is requesting, it is granted and burst_cnt=1.
- burst_cnt never exceeds MAX_BURST.
- With MAX_BURST=1 and both masters requesting continuously, grants strictly alternate.

Test Plan:
- Reset, then both req reads (m0 addr 0x10, m1 addr 0x20) in cycle 1 -> m0 granted first (o_ram_addr=0x10). Next cycle o_m0_rvalid=1 with RAM data; m1 rvalid=0.
- MAX_BURST=4, both req held continuously for 12 cycles -> grant pattern m0×4, m1×4, m0×4; exactly one gnt per cycle.
- m1 writes we=4'b0011, addr 0x3FF, wdata 0xDEADBEEF while m0 idle -> o_ram_we=0011, o_ram_addr=0x3FF, o_ram_wdata=0xDEADBEEF same cycle; no rvalid on either master next cycle.
- Alternating single-cycle reads m0, m1, m0 with RAM returning 0xA, 0xB, 0xC -> m0 rvalid/0xA, m1 rvalid/0xB, m0 rvalid/0xC on consecutive cycles; no cross-routing.
- m0 bursts 2 grants, idles 1 cycle, then both req -> m1 granted (burst broken by idle, round-robin to ~last_gnt).
- m0 read granted, i_rst asserted on the next edge -> o_m0_rvalid=0 in the cycle after reset; arbitration restarts with m0 priority.

Source files
------------

// File: rtl/ecore_ram_arbiter.sv
// Two-master round-robin arbiter for the shared synchronous data RAM port.
// Grants are combinational; read data is routed back one cycle after the grant.
module ecore_ram_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic [3:0]  i_m0_we,
  input  logic [29:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic [3:0]  i_m1_we,
  input  logic [29:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic [3:0]  o_ram_we,
  output logic [29:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  input  logic [31:0] i_ram_rdata
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);

  logic               last_gnt_q, last_gnt_d;
  logic               prev_active_q, prev_active_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic               rd_owner_q, rd_owner_d;

  logic sel;
  logic gnt;
  logic rd_valid;

  always_comb begin
    // With a single requester sel simply follows i_m1_req.
    if (i_m0_req && i_m1_req) begin
      sel = (prev_active_q && (burst_cnt_q < MAX_B)) ? last_gnt_q : ~last_gnt_q;
    end else begin
      sel = i_m1_req;
    end
    gnt = (i_m0_req | i_m1_req) & ~i_rst;
  end

  assign o_m0_gnt    = gnt & ~sel;
  assign o_m1_gnt    = gnt & sel;
  assign o_ram_we    = gnt ? (sel ? i_m1_we    : i_m0_we)    : 4'd0;
  assign o_ram_addr  = gnt ? (sel ? i_m1_addr  : i_m0_addr)  : 30'd0;
  assign o_ram_wdata = gnt ? (sel ? i_m1_wdata : i_m0_wdata) : 32'd0;

  assign rd_valid    = rd_pend_q & ~i_rst;
  assign o_m0_rvalid = rd_valid & ~rd_owner_q;
  assign o_m1_rvalid = rd_valid & rd_owner_q;
  assign o_m0_rdata  = o_m0_rvalid ? i_ram_rdata : 32'd0;
  assign o_m1_rdata  = o_m1_rvalid ? i_ram_rdata : 32'd0;

  always_comb begin
    last_gnt_d    = last_gnt_q;
    prev_active_d = 1'b0;
    burst_cnt_d   = burst_cnt_q;
    rd_pend_d     = 1'b0;
    rd_owner_d    = rd_owner_q;
    if (gnt) begin
      if ((sel == last_gnt_q) && prev_active_q) begin
        burst_cnt_d = (burst_cnt_q >= MAX_B) ? MAX_B : burst_cnt_q + ONE_B;
      end else begin
        burst_cnt_d = ONE_B;
      end
      last_gnt_d    = sel;
      prev_active_d = 1'b1;
      rd_pend_d     = (o_ram_we == 4'd0);
      rd_owner_d    = sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_gnt_q    <= 1'b1;
      prev_active_q <= 1'b0;
      burst_cnt_q   <= '0;
      rd_pend_q     <= 1'b0;
      rd_owner_q    <= 1'b0;
    end else begin
      last_gnt_q    <= last_gnt_d;
      prev_active_q <= prev_active_d;
      burst_cnt_q   <= burst_cnt_d;
      rd_pend_q     <= rd_pend_d;
      rd_owner_q    <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_ecore_ram_arbiter.sv
// Scoreboard bench: a history-based arbitration model predicts each cycle's grant and
// read return; a negedge monitor compares them against the DUT.
module tb_ecore_ram_arbiter;

  localparam int MB = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_m0_req = 1'b0, i_m1_req = 1'b0;
  logic [3:0]  i_m0_we = '0, i_m1_we = '0;
  logic [29:0] i_m0_addr = '0, i_m1_addr = '0;
  logic [31:0] i_m0_wdata = '0, i_m1_wdata = '0;
  logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic [3:0]  o_ram_we;
  logic [29:0] o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [31:0] i_ram_rdata = '0;

  ecore_ram_arbiter #(.MAX_BURST(MB), .BURST_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(i_ram_rdata)
  );

  always #5 i_clk = ~i_clk;

  // RAM macro model, driven only by the DUT's RAM port
  logic [31:0] ram_mem [1024];
  bit          ram_init = 1'b0;
  always @(posedge i_clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= 32'h5A00_0000 + 32'(i * 977);
      ram_init <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (o_ram_we[b]) ram_mem[o_ram_addr[9:0]][8*b +: 8] <= o_ram_wdata[8*b +: 8];
      i_ram_rdata <= ram_mem[o_ram_addr[9:0]];
    end
  end

  typedef struct packed {
    logic        g0, g1;
    logic [3:0]  we;
    logic [29:0] addr;
    logic [31:0] wd;
  } gexp_t;
  typedef struct {
    int          due;
    int          owner;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    hist[$];
  logic [31:0] ref_mem [1024];

  logic        p_req [2];
  logic [3:0]  p_we [2];
  logic [29:0] p_addr [2];
  logic [31:0] p_wdata [2];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Winner from grant history: a master that won the immediately preceding cycles keeps
  // the port until it has MB consecutive wins; otherwise the other master of the most
  // recent grant wins. Empty history (just out of reset) behaves as if master 1 went last.
  function automatic int pick();
    int last_m, streak;
    if (!p_req[0] && !p_req[1]) return -1;
    if (p_req[0] != p_req[1]) return p_req[0] ? 0 : 1;
    last_m = 1;
    for (int k = hist.size() - 1; k >= 0; k--)
      if (hist[k] >= 0) begin last_m = hist[k]; break; end
    if (hist.size() > 0 && hist[hist.size()-1] >= 0) begin
      streak = 0;
      for (int k = hist.size() - 1; k >= 0 && hist[k] == last_m; k--) streak++;
      if (streak < MB) return last_m;
    end
    return 1 - last_m;
  endfunction

  task automatic issue(int m, logic [3:0] we, logic [29:0] a, logic [31:0] d);
    p_req[m] = 1'b1; p_we[m] = we; p_addr[m] = a; p_wdata[m] = d;
  endtask

  task automatic drive_cycle();
    gexp_t g;
    rexp_t r;
    int    w;
    cyc++;
    i_m0_req = p_req[0]; i_m0_we = p_we[0]; i_m0_addr = p_addr[0]; i_m0_wdata = p_wdata[0];
    i_m1_req = p_req[1]; i_m1_we = p_we[1]; i_m1_addr = p_addr[1]; i_m1_wdata = p_wdata[1];
    g = '0;
    if (i_rst) begin
      for (int k = rq.size() - 1; k >= 0; k--) if (rq[k].due == cyc) rq.delete(k);
      hist.delete();
    end else begin
      w = pick();
      if (w >= 0) begin
        g.g0 = (w == 0); g.g1 = (w == 1);
        g.we = p_we[w]; g.addr = p_addr[w]; g.wd = p_wdata[w];
        if (p_we[w] == 4'd0) begin
          r.due = cyc + 1; r.owner = w; r.data = ref_mem[p_addr[w][9:0]];
          rq.push_back(r);
        end else begin
          for (int b = 0; b < 4; b++)
            if (p_we[w][b]) ref_mem[p_addr[w][9:0]][8*b +: 8] = p_wdata[w][8*b +: 8];
        end
        p_req[w] = 1'b0;
      end
      hist.push_back(w);
      if (hist.size() > 20) void'(hist.pop_front());
    end
    gq.push_back(g);
  endtask

  task automatic step();
    drive_cycle();
    @(posedge i_clk); #1;
  endtask

  task automatic next_edge();
    @(posedge i_clk); #1;
  endtask

  // Monitor
  initial begin
    gexp_t g;
    forever begin
      @(negedge i_clk);
      if (gq.size() > 0) begin
        g = gq.pop_front();
        chk("m0_gnt", 64'(o_m0_gnt), 64'(g.g0));
        chk("m1_gnt", 64'(o_m1_gnt), 64'(g.g1));
        chk("ram_we", 64'(o_ram_we), 64'(g.we));
        chk("ram_addr", 64'(o_ram_addr), 64'(g.addr));
        chk("ram_wdata", 64'(o_ram_wdata), 64'(g.wd));
        if (rq.size() > 0 && rq[0].due == cyc) begin
          chk("m0_rvalid", 64'(o_m0_rvalid), 64'(rq[0].owner == 0));
          chk("m1_rvalid", 64'(o_m1_rvalid), 64'(rq[0].owner == 1));
          chk("m0_rdata", 64'(o_m0_rdata), (rq[0].owner == 0) ? 64'(rq[0].data) : 64'd0);
          chk("m1_rdata", 64'(o_m1_rdata), (rq[0].owner == 1) ? 64'(rq[0].data) : 64'd0);
          void'(rq.pop_front());
        end else begin
          chk("idle_rvalid", 64'({o_m0_rvalid, o_m1_rvalid}), 64'd0);
          chk("idle_rdata", {o_m0_rdata, o_m1_rdata}, 64'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h5A00_0000 + 32'(i * 977);
    for (int m = 0; m < 2; m++) begin
      p_req[m] = 1'b0; p_we[m] = '0; p_addr[m] = '0; p_wdata[m] = '0;
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    repeat (3) step();
    i_rst = 1'b0;

    // both read in the first cycle: m0 wins, m1 follows
    issue(0, 4'd0, 30'h10, 32'd0);
    issue(1, 4'd0, 30'h20, 32'd0);
    drive_cycle();
    @(negedge i_clk);
    chk("first_addr", 64'(o_ram_addr), 64'h10);
    chk("first_gnt_m0", 64'(o_m0_gnt), 64'd1);
    next_edge();
    drive_cycle();
    @(negedge i_clk);
    chk("first_rvalid_m0", 64'(o_m0_rvalid), 64'd1);
    chk("first_m1_gnt", 64'(o_m1_gnt), 64'd1);
    next_edge();
    step();

    // continuous contention from reset: m0 x4, m1 x4, m0 x4
    i_rst = 1'b1; step(); i_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!p_req[0]) issue(0, 4'd0, 30'(i), 32'd0);
      if (!p_req[1]) issue(1, 4'hF, 30'(100 + i), 32'hC0DE_0000 + 32'(i));
      drive_cycle();
      @(negedge i_clk);
      chk("burst_m0_gnt", 64'(o_m0_gnt), 64'(i < 4 || i >= 8));
      chk("burst_one_hot", 64'(o_m0_gnt) + 64'(o_m1_gnt), 64'd1);
      next_edge();
    end
    while (p_req[0] || p_req[1]) step();
    step();

    // m1 partial write while m0 idle
    issue(1, 4'b0011, 30'h3FF, 32'hDEADBEEF);
    drive_cycle();
    @(negedge i_clk);
    chk("wr_we", 64'(o_ram_we), 64'h3);
    chk("wr_addr", 64'(o_ram_addr), 64'h3FF);
    chk("wr_wdata", 64'(o_ram_wdata), 64'hDEADBEEF);
    next_edge();
    step();

    // alternating single reads
    issue(0, 4'd0, 30'h3FF, 32'd0); step();
    issue(1, 4'd0, 30'h10, 32'd0);  step();
    issue(0, 4'd0, 30'h20, 32'd0);  step();
    step();

    // burst broken by idle cycle
    issue(0, 4'd0, 30'h1, 32'd0); step();
    issue(0, 4'd0, 30'h2, 32'd0); step();
    step();
    issue(0, 4'd0, 30'h3, 32'd0);
    issue(1, 4'd0, 30'h4, 32'd0);
    drive_cycle();
    @(negedge i_clk);
    chk("idle_break_m1_gnt", 64'(o_m1_gnt), 64'd1);
    next_edge();
    while (p_req[0] || p_req[1]) step();
    step();

    // reset while a read is pending
    issue(0, 4'd0, 30'h5, 32'd0); step();
    i_rst = 1'b1;
    drive_cycle();
    @(negedge i_clk);
    chk("rst_rvalid_m0", 64'(o_m0_rvalid), 64'd0);
    next_edge();
    i_rst = 1'b0;
    step();
    issue(0, 4'd0, 30'h6, 32'd0);
    issue(1, 4'd0, 30'h7, 32'd0);
    drive_cycle();
    @(negedge i_clk);
    chk("post_rst_m0_gnt", 64'(o_m0_gnt), 64'd1);
    next_edge();

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      i_rst = ($urandom_range(0, 199) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!p_req[m] && $urandom_range(0, 3) != 0) begin
          t = $urandom();
          issue(m, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                30'($urandom_range(0, 31)), t);
        end
      end
      step();
    end
    i_rst = 1'b0;
    for (int n = 0; n < 20 && (p_req[0] || p_req[1]); n++) step();
    step(); step();
    chk("drained_reads", 64'(rq.size()), 64'd0);
    chk("drained_reqs", 64'({p_req[0], p_req[1]}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
